// File: rtl/fir_bist_pkg.sv
// Shared types, constants and the LFSR step function for the FIR BIST pattern generator.
package fir_bist_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP    = 2'd0,
    MODE_LFSR    = 2'd1,
    MODE_IMPULSE = 2'd2,
    MODE_CONST   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // One step of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR (shift right, feedback into bit 15).
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // An all-zero state would lock the LFSR, so substitute the default seed.
  function automatic logic [15:0] lfsr_seed(input logic [15:0] s);
    return (s == 16'h0000) ? LFSR_DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/fir_bist_gen_if.sv
// AXI4-Stream beat channel between the BIST generator and the FIR slave input.
interface fir_bist_gen_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TLAST;
  logic                  TVALID;
  logic                  TREADY;

  modport master (output TDATA, output TLAST, output TVALID, input TREADY);
  modport slave  (input TDATA, input TLAST, input TVALID, output TREADY);

endinterface

// File: rtl/fir_bist_lfsr.sv
// 16-bit Fibonacci LFSR with synchronous reload to the seed and an advance enable.
module fir_bist_lfsr
  import fir_bist_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] state
);

  localparam logic [15:0] SEED_EFF = lfsr_seed(SEED);

  // State register: reload wins over advance so a new run always starts at the seed.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED_EFF;
    end else if (load) begin
      state <= SEED_EFF;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/fir_bist_gen.sv
// AXI4-Stream BIST packet generator: ramp, LFSR, impulse and constant patterns,
// NUM_OF_SAMPLES beats per packet, a counted or continuous run ended by count or STOP.
module fir_bist_gen
  import fir_bist_pkg::*;
#(
  parameter int          DATA_WIDTH     = 16,
  parameter int          NUM_OF_SAMPLES = 1000,
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter logic [15:0] AMPLITUDE      = 16'h4000
) (
  input  logic        M_AXIS_ACLK,
  input  logic        M_AXIS_ARESETN,
  input  logic        START,
  input  logic        STOP,
  input  logic [1:0]  MODE,
  input  logic [15:0] NUM_PACKETS,
  output logic        BUSY,
  output logic        DONE,
  fir_bist_gen_if.master M_AXIS
);

  localparam int                    IDX_W      = $clog2(NUM_OF_SAMPLES);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_OF_SAMPLES - 1);
  localparam logic [DATA_WIDTH-1:0] RAMP_START = DATA_WIDTH'(SEED);
  localparam logic [DATA_WIDTH-1:0] AMP_VAL    = DATA_WIDTH'(AMPLITUDE);
  localparam logic [DATA_WIDTH-1:0] LFSR_FIRST = DATA_WIDTH'(lfsr_seed(SEED));

  state_e                state;
  mode_e                 mode_q;
  logic [15:0]           num_pkts_q;
  logic [15:0]           pkt_cnt;
  logic                  stop_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] ramp_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tlast_q;
  logic                  tvalid_q;
  logic                  busy_q;
  logic                  done_q;

  logic [15:0]           lfsr_state;
  logic                  accept;
  logic                  lfsr_load;
  logic [IDX_W-1:0]      idx_next;
  logic [DATA_WIDTH-1:0] ramp_next;
  logic [DATA_WIDTH-1:0] lfsr_data_next;
  logic [15:0]           pkt_cnt_next;
  logic                  end_run;

  // Sample value for a beat given the pattern mode and the per-beat sources.
  function automatic logic [DATA_WIDTH-1:0] beat_data(
    input mode_e                 m,
    input logic [IDX_W-1:0]      idx,
    input logic [DATA_WIDTH-1:0] ramp,
    input logic [DATA_WIDTH-1:0] lfsr
  );
    case (m)
      MODE_RAMP:    return ramp;
      MODE_LFSR:    return lfsr;
      MODE_IMPULSE: return (idx == '0) ? AMP_VAL : '0;
      default:      return AMP_VAL;
    endcase
  endfunction

  assign accept    = tvalid_q & M_AXIS.TREADY;
  assign lfsr_load = (state == IDLE) && START;

  fir_bist_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (M_AXIS_ACLK),
    .rst_n   (M_AXIS_ARESETN),
    .load    (lfsr_load),
    .advance (accept),
    .state   (lfsr_state)
  );

  // Next-beat sources, used only when a beat is accepted.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    idx_next       = '0;
    ramp_next      = ramp_q + DATA_WIDTH'(1);
    lfsr_data_next = DATA_WIDTH'(lfsr_next(lfsr_state));
    pkt_cnt_next   = pkt_cnt + 16'd1;
    end_run        = 1'b0;
    if (!tlast_q) begin
      idx_next = idx_q + IDX_W'(1);
    end
    if (tlast_q) begin
      end_run = ((num_pkts_q != 16'd0) && (pkt_cnt_next == num_pkts_q)) || stop_q || STOP;
    end
  end

  // Run FSM with registered stream and status outputs.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state      <= IDLE;
      mode_q     <= MODE_RAMP;
      num_pkts_q <= '0;
      pkt_cnt    <= '0;
      stop_q     <= 1'b0;
      idx_q      <= '0;
      ramp_q     <= '0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          stop_q <= 1'b0;
          if (START) begin
            state      <= RUN;
            mode_q     <= mode_e'(MODE);
            num_pkts_q <= NUM_PACKETS;
            stop_q     <= STOP;
            pkt_cnt    <= '0;
            idx_q      <= '0;
            ramp_q     <= RAMP_START;
            tdata_q    <= beat_data(mode_e'(MODE), '0, RAMP_START, LFSR_FIRST);
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (STOP) begin
            stop_q <= 1'b1;
          end
          if (accept) begin
            idx_q  <= idx_next;
            ramp_q <= ramp_next;
            if (tlast_q) begin
              pkt_cnt <= pkt_cnt_next;
            end
            if (end_run) begin
              state    <= FINISH;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              tdata_q <= beat_data(mode_q, idx_next, ramp_next, lfsr_data_next);
              tlast_q <= (idx_next == LAST_IDX);
            end
          end
        end
        FINISH: begin
          done_q <= 1'b0;
          stop_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign M_AXIS.TDATA  = tdata_q;
  assign M_AXIS.TLAST  = tlast_q;
  assign M_AXIS.TVALID = tvalid_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;

endmodule

// File: tb/tb_fir_bist_gen.sv
// Self-checking bench for fir_bist_gen: random backpressure checked against a
// beat-indexed reference sequence built from the pattern rules.
module tb_fir_bist_gen;

  localparam int          DW   = 16;
  localparam int          N    = 8;
  localparam logic [15:0] SEED = 16'h0000;
  localparam logic [15:0] AMP  = 16'h4000;

  logic        clk;
  logic        rst_n;
  logic        start, stop;
  logic [1:0]  mode;
  logic [15:0] num_packets;
  logic        busy, done;

  logic        start1;
  logic        busy1, done1;

  int          n_checks;
  int          n_fail;
  logic [15:0] exp_data[$];
  bit          exp_last[$];
  logic [15:0] first0, first1;

  fir_bist_gen_if #(.DATA_WIDTH(DW)) axis0 ();
  fir_bist_gen_if #(.DATA_WIDTH(DW)) axis1 ();

  fir_bist_gen #(
    .DATA_WIDTH     (DW),
    .NUM_OF_SAMPLES (N),
    .SEED           (SEED),
    .AMPLITUDE      (AMP)
  ) dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .START          (start),
    .STOP           (stop),
    .MODE           (mode),
    .NUM_PACKETS    (num_packets),
    .BUSY           (busy),
    .DONE           (done),
    .M_AXIS         (axis0.master)
  );

  fir_bist_gen #(
    .DATA_WIDTH     (DW),
    .NUM_OF_SAMPLES (4),
    .SEED           (16'hFFFE),
    .AMPLITUDE      (AMP)
  ) dut_wrap (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .START          (start1),
    .STOP           (1'b0),
    .MODE           (2'd0),
    .NUM_PACKETS    (16'd1),
    .BUSY           (busy1),
    .DONE           (done1),
    .M_AXIS         (axis1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beat stream for a run of 'total' beats, indexed by beat number since START.
  task automatic build_expected(input logic [1:0] m, input int total);
    logic [15:0] lf;
    logic [15:0] d;
    lf = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    exp_data.delete();
    exp_last.delete();
    for (int b = 0; b < total; b++) begin
      case (m)
        2'd0:    d = 16'(SEED + 16'(b));
        2'd1:    d = lf;
        2'd2:    d = ((b % N) == 0) ? AMP : 16'h0000;
        default: d = AMP;
      endcase
      exp_data.push_back(d);
      exp_last.push_back((b % N) == N - 1);
      lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
    end
  endtask

  // stall_kind: 0 always ready, 1 ready low on cycles 3-5 after START, 2 random.
  task automatic do_run(input logic [1:0] m, input int npk, input int stall_kind,
                        input int stop_beat, input bit stop_with_start,
                        input int restart_beat, input int reset_beat);
    int total;
    int b;
    int cyc;
    bit stop_sent;
    bit restart_sent;
    if (stop_with_start) total = N;
    else if (stop_beat >= 0) begin
      total = (stop_beat / N + 1) * N;
      if (npk != 0 && npk * N < total) total = npk * N;
    end else total = npk * N;
    build_expected(m, total);

    mode = m;
    num_packets = 16'(npk);
    start = 1'b1;
    stop = stop_with_start;
    axis0.TREADY = 1'b0;
    tick();
    start = 1'b0;
    stop = 1'b0;
    mode = ~m;
    num_packets = 16'($urandom_range(1, 5));
    check("start_latency_tvalid", {31'd0, axis0.TVALID}, 32'd1);

    b = 0;
    cyc = 0;
    stop_sent = 1'b0;
    restart_sent = 1'b0;
    while (b < total && cyc < 600) begin
      cyc++;
      if (b == reset_beat) begin
        rst_n = 1'b0;
        #1;
        check("rst_tvalid", {31'd0, axis0.TVALID}, 32'd0);
        check("rst_tlast", {31'd0, axis0.TLAST}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_tdata", {16'd0, axis0.TDATA}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_tvalid", {31'd0, axis0.TVALID}, 32'd0);
        return;
      end
      case (stall_kind)
        0:       axis0.TREADY = 1'b1;
        1:       axis0.TREADY = !(cyc >= 3 && cyc <= 5);
        default: axis0.TREADY = ($urandom_range(0, 3) != 0);
      endcase
      if (b == stop_beat && !stop_sent) begin
        stop = 1'b1;
        stop_sent = 1'b1;
      end
      if (b == restart_beat && !restart_sent) begin
        start = 1'b1;
        restart_sent = 1'b1;
      end
      check($sformatf("tvalid[%0d]", b), {31'd0, axis0.TVALID}, 32'd1);
      check($sformatf("busy[%0d]", b), {31'd0, busy}, 32'd1);
      check($sformatf("tdata[%0d]", b), {16'd0, axis0.TDATA}, {16'd0, exp_data[b]});
      check($sformatf("tlast[%0d]", b), {31'd0, axis0.TLAST}, {31'd0, exp_last[b]});
      if (b == 0) first0 = axis0.TDATA;
      if (b == 1) first1 = axis0.TDATA;
      if (axis0.TVALID && axis0.TREADY) b++;
      tick();
      start = 1'b0;
      stop = 1'b0;
    end
    check("beats_delivered", b, total);
    check("finish_done", {31'd0, done}, 32'd1);
    check("finish_busy", {31'd0, busy}, 32'd0);
    check("finish_tvalid", {31'd0, axis0.TVALID}, 32'd0);
    tick();
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_tvalid", {31'd0, axis0.TVALID}, 32'd0);
  endtask

  initial begin
    logic [15:0] wrap_exp[3];
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    mode = 2'd0;
    num_packets = 16'd0;
    start1 = 1'b0;
    axis0.TREADY = 1'b0;
    axis1.TREADY = 1'b0;
    wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000};
    tick();
    check("reset_tvalid", {31'd0, axis0.TVALID}, 32'd0);
    check("reset_tlast", {31'd0, axis0.TLAST}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_tdata", {16'd0, axis0.TDATA}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Ramp, two packets, no backpressure.
    do_run(2'd0, 2, 0, -1, 1'b0, -1, -1);
    // Ramp with a three-cycle stall on beat 2.
    do_run(2'd0, 1, 1, -1, 1'b0, -1, -1);
    // LFSR with a stall; zero seed falls back to the default seed.
    do_run(2'd1, 1, 1, -1, 1'b0, -1, -1);
    check("lfsr_beat0", {16'd0, first0}, 32'h0000ACE1);
    check("lfsr_beat1", {16'd0, first1}, 32'h00005670);
    // Impulse and constant under random backpressure.
    do_run(2'd2, 3, 2, -1, 1'b0, -1, -1);
    do_run(2'd3, 2, 2, -1, 1'b0, -1, -1);
    // Continuous runs ended by STOP mid-packet and on the TLAST beat; START during RUN ignored.
    do_run(2'd0, 0, 2, 12, 1'b0, 5, -1);
    do_run(2'd1, 0, 0, 15, 1'b0, -1, -1);
    // START and STOP together: exactly one packet.
    do_run(2'd3, 5, 0, -1, 1'b1, -1, -1);
    // STOP while idle has no effect on the following run.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("idle_stop_busy", {31'd0, busy}, 32'd0);
    tick();
    do_run(2'd0, 2, 2, -1, 1'b0, -1, -1);
    // Reset at beat 4, then a fresh run replays from the seed.
    do_run(2'd0, 2, 0, -1, 1'b0, -1, 4);
    do_run(2'd0, 1, 0, -1, 1'b0, -1, -1);
    // Random mixed runs.
    for (int r = 0; r < 6; r++) begin
      do_run(2'($urandom_range(0, 3)), $urandom_range(1, 3), 2, -1, 1'b0, -1, -1);
    end

    // Ramp wrap on a second instance seeded at 16'hFFFE.
    axis1.TREADY = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wrap_tvalid[%0d]", i), {31'd0, axis1.TVALID}, 32'd1);
      check($sformatf("wrap_tdata[%0d]", i), {16'd0, axis1.TDATA}, {16'd0, wrap_exp[i]});
      tick();
    end
    for (int i = 0; i < 20 && !done1; i++) tick();
    check("wrap_done", {31'd0, done1}, 32'd1);
    tick();
    check("wrap_busy", {31'd0, busy1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
